// File: rtl/onn_pkg.sv
// Shared types and helpers for the ONN phase-scan logic.
// Holds the scan FSM state encoding, the arm-watchdog width and the
// saturation helper used to size the phase counter limit.
package onn_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_COUNT,
    S_WRITE,
    S_NEXT,
    S_FIN
  } scan_state_t;

  // Width of the arm watchdog; ARM_TO must fit in this many bits.
  localparam int WD_W = 8;

  // Largest value a cnt_w-bit unsigned counter can hold.
  function automatic int sat_max(input int cnt_w);
    return (1 << cnt_w) - 1;
  endfunction

endpackage

// File: rtl/osc_edge_det.sv
// Purpose: registers the oscillator inputs and flags per-neuron rising edges.
// Latency: rise is combinational from osc_in against last cycle's copy (0 cycles).
// Backpressure: none; free-running every cycle.
module osc_edge_det #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] osc_in,
  output logic [N-1:0] rise
);

  logic [N-1:0] osc_q;

  // Previous-cycle copy; cleared by reset so an input already high gives one rise.
  always_ff @(posedge clk) begin
    if (!rst_n) osc_q <= '0;
    else        osc_q <= osc_in;
  end

  assign rise = osc_in & ~osc_q;

endmodule

// File: rtl/phase_scan_ctrl.sv
// Purpose: walks every neuron, measuring reference-to-target rising-edge delay with one shared counter.
// Latency: one result write per neuron; write lands 1 cycle after the target rise, reference slot is 3 cycles.
// Backpressure: none; res_we is a fire-and-forget strobe, start is only sampled when idle.
module phase_scan_ctrl
  import onn_pkg::*;
#(
  parameter int N_NEUR = 8,
  parameter int CNT_W  = 4,
  parameter int ARM_TO = 255,
  parameter int IDX_W  = $clog2(N_NEUR)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N_NEUR-1:0] osc_in,
  input  logic [IDX_W-1:0]  ref_sel,
  output logic              busy,
  output logic              done,
  output logic              res_we,
  output logic [IDX_W-1:0]  res_addr,
  output logic [CNT_W-1:0]  res_data,
  output logic              res_to
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(sat_max(CNT_W));
  localparam logic [WD_W-1:0]  WD_LIM   = WD_W'(ARM_TO);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_NEUR - 1);

  scan_state_t       state, state_nxt;
  logic [IDX_W-1:0]  ref_r, ref_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [WD_W-1:0]   wd, wd_nxt, wd_inc;
  logic [N_NEUR-1:0] rise;
  logic              rise_ref, rise_tgt;
  logic              res_ld;
  logic [CNT_W-1:0]  res_data_nxt;
  logic              res_to_nxt;

  osc_edge_det #(.N(N_NEUR)) u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .osc_in (osc_in),
    .rise   (rise)
  );

  assign rise_ref = rise[ref_r];
  assign rise_tgt = rise[idx];
  assign wd_inc   = wd + WD_W'(1);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state, counter updates and result capture; res_ld marks entry into WRITE.
  always_comb begin
    state_nxt    = state;
    ref_nxt      = ref_r;
    idx_nxt      = idx;
    cnt_nxt      = cnt;
    wd_nxt       = wd;
    res_ld       = 1'b0;
    res_data_nxt = '0;
    res_to_nxt   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          ref_nxt   = ref_sel;
          idx_nxt   = '0;
          wd_nxt    = '0;
          state_nxt = S_ARM;
        end
      end
      S_ARM: begin
        if (idx == ref_r) begin
          // Reference against itself: phase is zero by definition.
          res_ld    = 1'b1;
          state_nxt = S_WRITE;
        end else if (rise_ref && rise_tgt) begin
          res_ld    = 1'b1;
          state_nxt = S_WRITE;
        end else if (rise_ref) begin
          cnt_nxt   = CNT_W'(1);
          state_nxt = S_COUNT;
        end else if (wd_inc == WD_LIM) begin
          res_ld       = 1'b1;
          res_data_nxt = CNT_MAX;
          res_to_nxt   = 1'b1;
          state_nxt    = S_WRITE;
        end else begin
          wd_nxt = wd_inc;
        end
      end
      S_COUNT: begin
        // Extra reference edges are deliberately not looked at here.
        if (rise_tgt) begin
          res_ld       = 1'b1;
          res_data_nxt = cnt;
          state_nxt    = S_WRITE;
        end else if (cnt == CNT_MAX) begin
          res_ld       = 1'b1;
          res_data_nxt = CNT_MAX;
          res_to_nxt   = 1'b1;
          state_nxt    = S_WRITE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_WRITE: state_nxt = S_NEXT;
      S_NEXT: begin
        if (idx == IDX_LAST) begin
          state_nxt = S_FIN;
        end else begin
          idx_nxt   = idx + IDX_W'(1);
          wd_nxt    = '0;
          state_nxt = S_ARM;
        end
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers and registered outputs, all derived from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ref_r    <= '0;
      idx      <= '0;
      cnt      <= '0;
      wd       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      res_we   <= 1'b0;
      res_addr <= '0;
      res_data <= '0;
      res_to   <= 1'b0;
    end else begin
      ref_r  <= ref_nxt;
      idx    <= idx_nxt;
      cnt    <= cnt_nxt;
      wd     <= wd_nxt;
      busy   <= (state_nxt != S_IDLE) && (state_nxt != S_FIN);
      done   <= (state_nxt == S_FIN);
      res_we <= res_ld;
      if (res_ld) begin
        res_addr <= idx;
        res_data <= res_data_nxt;
        res_to   <= res_to_nxt;
      end
    end
  end

endmodule

// File: tb/tb_phase_scan_ctrl.sv
// Purpose: directed and randomized scans of phase_scan_ctrl against a trace-based reference model.
// Latency: model predicts the exact cycle of every write and of done.
// Backpressure: not applicable; the bench drives one input vector per cycle.
module tb_phase_scan_ctrl;

  localparam int N    = 4;
  localparam int CW   = 4;
  localparam int ATO  = 255;
  localparam int IW   = 2;
  localparam int WLEN = 1600;
  localparam int SAT  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [N-1:0]  osc_in;
  logic [IW-1:0] ref_sel;
  logic          busy, done, res_we, res_to;
  logic [IW-1:0] res_addr;
  logic [CW-1:0] res_data;

  int total = 0;
  int bad   = 0;

  logic [N-1:0] wave [WLEN];
  logic [N-1:0] prev_osc;
  int e_cyc[$], e_addr[$], e_data[$], e_to[$];
  int e_done;
  int got_data [N];
  int got_to   [N];

  always #5 clk = ~clk;

  phase_scan_ctrl #(.N_NEUR(N), .CNT_W(CW), .ARM_TO(ATO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .osc_in   (osc_in),
    .ref_sel  (ref_sel),
    .busy     (busy),
    .done     (done),
    .res_we   (res_we),
    .res_addr (res_addr),
    .res_data (res_data),
    .res_to   (res_to)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Rising edge of neuron n in scan-relative cycle c.
  function automatic bit rise_at(input int c, input int n);
    logic p;
    p = (c == 0) ? prev_osc[n] : wave[c-1][n];
    return wave[c][n] && !p;
  endfunction

  task automatic gen_periodic(input int n, input int per, input int hi, input int off);
    for (int c = 0; c < WLEN; c++) wave[c][n] = (((c + off) % per) < hi);
  endtask

  task automatic gen_const(input int n, input bit v);
    for (int c = 0; c < WLEN; c++) wave[c][n] = v;
  endtask

  // Predict writes from the waveform: start in cycle 0, first ARM in cycle 1.
  task automatic build_expect(input int rs);
    int a, w, rc, d, to;
    bit found;
    e_cyc.delete(); e_addr.delete(); e_data.delete(); e_to.delete();
    a = 1;
    w = 0;
    for (int idx = 0; idx < N; idx++) begin
      if (idx == rs) begin
        w = a + 1; d = 0; to = 0;
      end else begin
        found = 0;
        rc    = 0;
        for (int c = a; c < a + ATO; c++)
          if (!found && rise_at(c, rs)) begin found = 1; rc = c; end
        if (!found) begin
          w = a + ATO; d = SAT; to = 1;
        end else if (rise_at(rc, idx)) begin
          w = rc + 1; d = 0; to = 0;
        end else begin
          w = rc + SAT + 1; d = SAT; to = 1;
          for (int t = rc + SAT; t > rc; t--)
            if (rise_at(t, idx)) begin w = t + 1; d = t - rc; to = 0; end
        end
      end
      e_cyc.push_back(w); e_addr.push_back(idx); e_data.push_back(d); e_to.push_back(to);
      a = w + 2;
    end
    e_done = w + 2;
  endtask

  // One full scan; returns on the done cycle so a following scan starts right after.
  task automatic run_scan(input int rs, input bit ign);
    int ei, ndone;
    build_expect(rs);
    ei    = 0;
    ndone = 0;
    for (int n = 0; n < N; n++) begin got_data[n] = -1; got_to[n] = -1; end
    for (int i = 0; i <= e_done; i++) begin
      @(posedge clk); #1;
      osc_in  = wave[i];
      start   = (i == 0) || (ign && (i == 6 || i == 7));
      ref_sel = (ign && i >= 3) ? 2'd2 : rs[IW-1:0];
      @(negedge clk);
      if (res_we) begin
        if (ei < e_cyc.size()) begin
          check("wr_cycle", i, e_cyc[ei]);
          check("wr_addr", res_addr, e_addr[ei]);
          check("wr_data", res_data, e_data[ei]);
          check("wr_to", res_to, e_to[ei]);
          got_data[res_addr] = res_data;
          got_to[res_addr]   = res_to;
        end else begin
          check("extra_write", ei, e_cyc.size());
        end
        ei++;
      end
      if (done) ndone++;
      if (i == 1) check("busy_after_start", busy, 1);
      if (i == e_done) begin
        check("done_at_end", done, 1);
        check("busy_at_done", busy, 0);
      end
    end
    check("write_count", ei, N);
    check("done_pulses", ndone, 1);
    prev_osc = wave[e_done];
    start    = 1'b0;
  endtask

  task automatic gen_random;
    int sel, per, hi, off;
    for (int n = 0; n < N; n++) begin
      sel = $urandom_range(0, 7);
      if (sel == 0) gen_const(n, 1'b0);
      else begin
        per = $urandom_range(4, 28);
        hi  = $urandom_range(1, per - 1);
        off = $urandom_range(0, per - 1);
        gen_periodic(n, per, hi, off);
      end
    end
  endtask

  initial begin
    int nwe, ndn;
    rst_n    = 1'b0;
    start    = 1'b0;
    osc_in   = '0;
    ref_sel  = '0;
    prev_osc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we", res_we, 0);
    check("rst_to", res_to, 0);
    check("rst_addr", res_addr, 0);
    check("rst_data", res_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic scan: neurons 1,2,3 rise 3,5,0 cycles after neuron 0.
    gen_periodic(0, 16, 8, 0);
    gen_periodic(1, 16, 8, 13);
    gen_periodic(2, 16, 8, 11);
    gen_periodic(3, 16, 8, 0);
    run_scan(0, 1'b0);
    check("basic_d0", got_data[0], 0);
    check("basic_d1", got_data[1], 3);
    check("basic_d2", got_data[2], 5);
    check("basic_d3", got_data[3], 0);
    check("basic_to1", got_to[1], 0);

    // Count saturation: neuron 0 never rises, reference is neuron 1.
    gen_const(0, 1'b0);
    gen_periodic(1, 20, 10, 0);
    gen_periodic(2, 20, 10, 13);
    gen_periodic(3, 20, 3, 5);
    run_scan(1, 1'b0);
    check("sat_data", got_data[0], SAT);
    check("sat_to", got_to[0], 1);

    // Arm timeout: reference neuron 2 held low.
    gen_periodic(0, 9, 4, 0);
    gen_periodic(1, 11, 5, 2);
    gen_const(2, 1'b0);
    gen_periodic(3, 7, 2, 1);
    run_scan(2, 1'b0);
    check("arm_to0", got_to[0], 1);
    check("arm_to3", got_to[3], 1);
    check("arm_data1", got_data[1], SAT);

    // Extra reference edges at 10 and 12, target rises at 16.
    gen_const(0, 1'b0);
    wave[10][0] = 1'b1;
    wave[12][0] = 1'b1;
    for (int c = 0; c < WLEN; c++) wave[c][1] = (c >= 16);
    gen_periodic(2, 13, 6, 3);
    gen_periodic(3, 10, 5, 7);
    run_scan(0, 1'b0);
    check("extra_ref_data", got_data[1], 6);
    check("extra_ref_to", got_to[1], 0);

    // Ignored start/ref_sel while busy, then a back-to-back start after done.
    gen_random();
    gen_periodic(0, 12, 6, 0);
    run_scan(0, 1'b1);
    gen_random();
    run_scan($urandom_range(0, N - 1), 1'b0);

    // Randomized scans.
    for (int k = 0; k < 6; k++) begin
      gen_random();
      run_scan($urandom_range(0, N - 1), 1'b0);
    end

    // Reset in the middle of a measurement.
    gen_const(0, 1'b0); gen_const(1, 1'b0); gen_const(2, 1'b0); gen_const(3, 1'b0);
    for (int c = 10; c < WLEN; c++) wave[c][0] = 1'b1;
    nwe = 0;
    ndn = 0;
    for (int i = 0; i <= 40; i++) begin
      @(posedge clk); #1;
      osc_in  = wave[i];
      start   = (i == 0);
      ref_sel = 2'd0;
      rst_n   = (i != 13);
      @(negedge clk);
      if (i == 12) check("busy_in_count", busy, 1);
      if (i == 14) begin
        check("rst_mid_busy", busy, 0);
        check("rst_mid_we", res_we, 0);
        check("rst_mid_done", done, 0);
      end
      if (i >= 14 && res_we) nwe++;
      if (i >= 14 && done) ndn++;
    end
    check("rst_mid_no_we", nwe, 0);
    check("rst_mid_no_done", ndn, 0);
    @(posedge clk); #1;
    osc_in   = '0;
    prev_osc = '0;
    repeat (2) @(posedge clk);

    // Scan still works after the mid-scan reset.
    gen_random();
    run_scan($urandom_range(0, N - 1), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
